mem_beat_bridge: RTL and testbench

MEM_BEAT_BRIDGE -- requirements
Module: mem_beat_bridge

---
 rtl/mem_bridge_pkg.sv | 20 ++
 rtl/mem_beat_bridge.sv | 138 +++++++++++++
 tb/tb_mem_beat_bridge.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared opcodes, widths and FSM state type for the line-to-beat memory bridge
package mem_bridge_pkg;

  localparam int DEF_LG_L1D_CL_LEN  = 4;
  localparam int DEF_BEAT_BITS      = 64;
  localparam int M_WIDTH            = 32;
  localparam int LG_MEM_TAG_ENTRIES = 4;

  // The upstream arbiter builds its requests from these same opcodes.
  localparam logic [4:0] MEM_LOAD_CL  = 5'h0C;
  localparam logic [4:0] MEM_STORE_CL = 5'h0D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } bridge_state_t;

endpackage

// File: rtl/mem_beat_bridge.sv
// rtl/mem_beat_bridge.sv - splits a cache-line request into sequential bus beats, one outstanding at a time
module mem_beat_bridge
  import mem_bridge_pkg::*;
#(
  parameter int LG_L1D_CL_LEN = DEF_LG_L1D_CL_LEN,
  parameter int BEAT_BITS     = DEF_BEAT_BITS,
  localparam int CL_BITS      = 8 << LG_L1D_CL_LEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_req_valid,
  output logic                          mem_req_ack,
  input  logic [M_WIDTH-1:0]            mem_req_addr,
  input  logic [CL_BITS-1:0]            mem_req_store_data,
  input  logic [LG_MEM_TAG_ENTRIES-1:0] mem_req_tag,
  input  logic                          mem_req_insn,
  input  logic [4:0]                    mem_req_opcode,
  output logic                          mem_rsp_valid,
  output logic [CL_BITS-1:0]            mem_rsp_load_data,
  output logic [LG_MEM_TAG_ENTRIES-1:0] mem_rsp_tag,
  output logic [4:0]                    mem_rsp_opcode,
  output logic                          bus_req_valid,
  input  logic                          bus_req_ready,
  output logic                          bus_req_write,
  output logic [M_WIDTH-1:0]            bus_req_addr,
  output logic [BEAT_BITS-1:0]          bus_req_wdata,
  input  logic                          bus_rsp_valid,
  input  logic [BEAT_BITS-1:0]          bus_rsp_rdata
);

  localparam int NBEATS = CL_BITS / BEAT_BITS;
  localparam int BW     = $clog2(NBEATS + 1);
  localparam logic [M_WIDTH-1:0] OFS_MASK   = M_WIDTH'((1 << LG_L1D_CL_LEN) - 1);
  localparam logic [M_WIDTH-1:0] BEAT_BYTES = M_WIDTH'(BEAT_BITS / 8);
  localparam logic [BW-1:0]      LAST_BEAT  = BW'(NBEATS - 1);

  bridge_state_t                 state_q;
  logic [M_WIDTH-1:0]            addr_q;
  logic [CL_BITS-1:0]            store_q;
  logic [CL_BITS-1:0]            load_q;
  logic [LG_MEM_TAG_ENTRIES-1:0] tag_q;
  logic [4:0]                    opcode_q;
  logic                          insn_q;
  logic                          ack_q;
  logic                          rsp_valid_q;
  logic                          bus_valid_q;
  logic [BW-1:0]                 beat_q;

  logic is_load;
  logic is_store;
  assign is_load  = (opcode_q == MEM_LOAD_CL);
  assign is_store = (opcode_q == MEM_STORE_CL);

  // insn is captured with the request but nothing downstream consumes it yet.
  logic unused_insn;
  assign unused_insn = insn_q;

  // The ack cycle is spent in IDLE so the first beat lands one cycle after ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      store_q     <= '0;
      load_q      <= '0;
      tag_q       <= '0;
      opcode_q    <= '0;
      insn_q      <= 1'b0;
      ack_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      bus_valid_q <= 1'b0;
      beat_q      <= '0;
    end else begin
      ack_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ack_q) begin
            if (is_load || is_store) begin
              state_q     <= ISSUE;
              bus_valid_q <= 1'b1;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end
          end else if (mem_req_valid) begin
            ack_q    <= 1'b1;
            addr_q   <= mem_req_addr;
            store_q  <= mem_req_store_data;
            tag_q    <= mem_req_tag;
            opcode_q <= mem_req_opcode;
            insn_q   <= mem_req_insn;
            beat_q   <= '0;
            load_q   <= '0;
          end
        end
        ISSUE: begin
          if (bus_req_ready) begin
            bus_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (bus_rsp_valid) begin
            if (is_load) begin
              load_q[int'(beat_q)*BEAT_BITS +: BEAT_BITS] <= bus_rsp_rdata;
            end
            if (beat_q == LAST_BEAT) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              beat_q      <= beat_q + BW'(1);
              bus_valid_q <= 1'b1;
              state_q     <= ISSUE;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_ack       = ack_q;
  assign mem_rsp_valid     = rsp_valid_q;
  assign mem_rsp_load_data = load_q;
  assign mem_rsp_tag       = tag_q;
  assign mem_rsp_opcode    = opcode_q;

  assign bus_req_valid = bus_valid_q;
  assign bus_req_write = is_store;
  assign bus_req_addr  = (addr_q & ~OFS_MASK) + M_WIDTH'(beat_q) * BEAT_BYTES;
  assign bus_req_wdata = store_q[int'(beat_q)*BEAT_BITS +: BEAT_BITS];

endmodule

// File: tb/tb_mem_beat_bridge.sv
// tb/tb_mem_beat_bridge.sv - directed vector bench for mem_beat_bridge (128-bit line, 64-bit beats)
module tb_mem_beat_bridge;
  import mem_bridge_pkg::*;

  localparam int CLB = 128;
  localparam int BB  = 64;
  localparam int TW  = LG_MEM_TAG_ENTRIES;

  logic            clk = 1'b0;
  logic            reset;
  logic            mem_req_valid;
  logic            mem_req_ack;
  logic [31:0]     mem_req_addr;
  logic [CLB-1:0]  mem_req_store_data;
  logic [TW-1:0]   mem_req_tag;
  logic            mem_req_insn;
  logic [4:0]      mem_req_opcode;
  logic            mem_rsp_valid;
  logic [CLB-1:0]  mem_rsp_load_data;
  logic [TW-1:0]   mem_rsp_tag;
  logic [4:0]      mem_rsp_opcode;
  logic            bus_req_valid;
  logic            bus_req_ready;
  logic            bus_req_write;
  logic [31:0]     bus_req_addr;
  logic [BB-1:0]   bus_req_wdata;
  logic            bus_rsp_valid;
  logic [BB-1:0]   bus_rsp_rdata;

  always #5 clk = ~clk;

  mem_beat_bridge #(.LG_L1D_CL_LEN(4), .BEAT_BITS(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ack       (mem_req_ack),
    .mem_req_addr      (mem_req_addr),
    .mem_req_store_data(mem_req_store_data),
    .mem_req_tag       (mem_req_tag),
    .mem_req_insn      (mem_req_insn),
    .mem_req_opcode    (mem_req_opcode),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_load_data (mem_rsp_load_data),
    .mem_rsp_tag       (mem_rsp_tag),
    .mem_rsp_opcode    (mem_rsp_opcode),
    .bus_req_valid     (bus_req_valid),
    .bus_req_ready     (bus_req_ready),
    .bus_req_write     (bus_req_write),
    .bus_req_addr      (bus_req_addr),
    .bus_req_wdata     (bus_req_wdata),
    .bus_rsp_valid     (bus_rsp_valid),
    .bus_rsp_rdata     (bus_rsp_rdata)
  );

  typedef struct {
    logic [4:0]     opcode;
    logic [31:0]    addr;
    logic [CLB-1:0] sdata;
    logic [TW-1:0]  tag;
    logic [BB-1:0]  rdata0;
    logic [BB-1:0]  rdata1;
    int             exp_beats;
    bit             exp_write;
    logic [31:0]    exp_a0;
    logic [31:0]    exp_a1;
    logic [BB-1:0]  exp_wd0;
    logic [BB-1:0]  exp_wd1;
    logic [CLB-1:0] exp_load;
  } vec_t;

  vec_t vecs[5];
  int   checks  = 0;
  int   errors  = 0;
  int   rsp_seen = 0;
  int   exp_rsp  = 0;

  always @(negedge clk) begin
    if (reset === 1'b1 && mem_rsp_valid === 1'b1) rsp_seen++;
  end

  task automatic chk(input string name, input logic [CLB-1:0] act, input logic [CLB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_txn(input vec_t v, input int stall, input bit keep_valid);
    bit hs;
    bit done;
    int beats;
    int stall_left;
    mem_req_valid      = 1'b1;
    mem_req_addr       = v.addr;
    mem_req_store_data = v.sdata;
    mem_req_tag        = v.tag;
    mem_req_opcode     = v.opcode;
    mem_req_insn       = 1'b0;
    exp_rsp++;
    step();
    chk("ack", mem_req_ack, 1);
    hs = 0; done = 0; beats = 0; stall_left = stall;
    for (int c = 1; c <= 40 && !done; c++) begin
      step();
      bus_rsp_valid = 1'b0;
      if (hs) begin
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = (beats == 1) ? v.rdata0 : v.rdata1;
        hs = 0;
      end
      chk("ack_busy", mem_req_ack, 0);
      if (bus_req_valid) begin
        if (v.exp_beats == 0) begin
          chk("no_bus", bus_req_valid, 0);
        end else begin
          chk("bus_addr", bus_req_addr, (beats == 0) ? v.exp_a0 : v.exp_a1);
          chk("bus_write", bus_req_write, v.exp_write);
          if (v.exp_write) chk("bus_wdata", bus_req_wdata, (beats == 0) ? v.exp_wd0 : v.exp_wd1);
          if (stall_left > 0) begin
            bus_req_ready = 1'b0;
            stall_left--;
          end else begin
            bus_req_ready = 1'b1;
            hs = 1;
            beats++;
          end
        end
      end
      if (mem_rsp_valid) begin
        done = 1;
        chk("rsp_cycle", c, (v.exp_beats == 0) ? 1 : 2 * v.exp_beats + 1 + stall);
        chk("rsp_data", mem_rsp_load_data, v.exp_load);
        chk("rsp_tag", mem_rsp_tag, v.tag);
        chk("rsp_opcode", mem_rsp_opcode, v.opcode);
        chk("beat_count", beats, v.exp_beats);
        if (!keep_valid) mem_req_valid = 1'b0;
      end
    end
    chk("rsp_timeout", done, 1);
    bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b0;
    step();
    chk("rsp_pulse", mem_rsp_valid, 0);
    chk("ack_after_rsp", mem_req_ack, 0);
  endtask

  initial begin
    vecs[0] = '{MEM_LOAD_CL, 32'h1008, '0, 4'h3, 64'hAAAA, 64'hBBBB,
                2, 1'b0, 32'h1000, 32'h1008, '0, '0, {64'hBBBB, 64'hAAAA}};
    vecs[1] = '{MEM_STORE_CL, 32'h2000, {64'h22, 64'h11}, 4'h5, 64'h5555, 64'h6666,
                2, 1'b1, 32'h2000, 32'h2008, 64'h11, 64'h22, '0};
    vecs[2] = '{MEM_LOAD_CL, 32'h3004F, 128'hCAFE, 4'hF, 64'hDEADBEEF01234567, 64'hFFFF0000FFFF0000,
                2, 1'b0, 32'h30040, 32'h30048, '0, '0, {64'hFFFF0000FFFF0000, 64'hDEADBEEF01234567}};
    vecs[3] = '{MEM_STORE_CL, 32'hFFFFFFF8, {64'h0123456789ABCDEF, 64'hFEDCBA9876543210}, 4'h0,
                64'h1, 64'h2, 2, 1'b1, 32'hFFFFFFF0, 32'hFFFFFFF8,
                64'hFEDCBA9876543210, 64'h0123456789ABCDEF, '0};
    vecs[4] = '{5'h1F, 32'h4000, 128'h1234, 4'h7, 64'h0, 64'h0,
                0, 1'b0, 32'h0, 32'h0, '0, '0, '0};

    reset = 1'b0;
    mem_req_valid = 1'b0; mem_req_addr = '0; mem_req_store_data = '0;
    mem_req_tag = '0; mem_req_insn = 1'b0; mem_req_opcode = '0;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", mem_req_ack, 0);
    chk("rst_rsp_valid", mem_rsp_valid, 0);
    chk("rst_bus_valid", bus_req_valid, 0);
    chk("rst_load_data", mem_rsp_load_data, 0);
    chk("rst_tag", mem_rsp_tag, 0);
    chk("rst_bus_addr", bus_req_addr, 0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_txn(vecs[i], 0, 1'b0);

    run_txn(vecs[1], 3, 1'b0);

    // held request across a busy load, then the follow-on request
    run_txn(vecs[0], 0, 1'b1);
    run_txn(vecs[2], 0, 1'b0);

    // reset while waiting on beat 1, then a stray bus response
    mem_req_valid = 1'b1; mem_req_addr = vecs[0].addr; mem_req_store_data = '0;
    mem_req_tag = vecs[0].tag; mem_req_opcode = vecs[0].opcode;
    step();
    chk("mid_ack", mem_req_ack, 1);
    step();
    chk("mid_beat0", bus_req_valid, 1);
    step();
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 64'h1111;
    step();
    bus_rsp_valid = 1'b0;
    chk("mid_beat1_addr", bus_req_addr, 32'h1008);
    step();
    reset = 1'b0; mem_req_valid = 1'b0;
    #1;
    chk("mid_rst_bus_valid", bus_req_valid, 0);
    chk("mid_rst_rsp_valid", mem_rsp_valid, 0);
    chk("mid_rst_load", mem_rsp_load_data, 0);
    chk("mid_rst_tag", mem_rsp_tag, 0);
    step();
    reset = 1'b1;
    step();
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 64'h9999;
    step();
    bus_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stray_rsp_valid", mem_rsp_valid, 0);
      chk("stray_bus_valid", bus_req_valid, 0);
      step();
    end
    run_txn(vecs[0], 0, 1'b0);

    chk("rsp_count", rsp_seen, exp_rsp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
